// File: rtl/dcache_pkg.sv
// Shared types and constants for the dcache tag RAM maintenance sequencer:
// tag entry layout, index width and controller state encoding.
package dcache_pkg;
  localparam int NUM_LINES  = 256;
  localparam int INDEX_W    = 8;
  localparam int TAG_W      = 21;
  localparam int VALID_BIT  = 20;
  localparam int DIRTY_BIT  = 19;
  localparam int ADDR_TAG_W = TAG_W - 2;

  typedef logic [INDEX_W-1:0]    index_t;
  typedef logic [ADDR_TAG_W-1:0] addr_tag_t;

  // Field order mirrors VALID_BIT / DIRTY_BIT / address-tag bit positions.
  typedef struct packed {
    logic      tag_valid;
    logic      tag_dirty;
    addr_tag_t tag_addr;
  } tag_entry_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_INV   = 3'd2,
    ST_F_RD  = 3'd3,
    ST_F_CHK = 3'd4,
    ST_F_WB  = 3'd5,
    ST_F_WR  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  localparam index_t LAST_IDX = index_t'(NUM_LINES - 1);
endpackage

// File: rtl/dcache_tag_maint_ctrl_if.sv
// Tag RAM read/write ports plus the writeback request handshake seen by the
// maintenance controller; master is the controller side.
interface dcache_tag_maint_ctrl_if;
  import dcache_pkg::*;

  index_t     tag_addr0;
  tag_entry_t tag_data0;
  index_t     tag_addr1;
  tag_entry_t tag_data1;
  logic       tag_wr1;

  logic       wb_req;
  index_t     wb_index;
  addr_tag_t  wb_tag;
  logic       wb_ack;

  modport master (
    output tag_addr0, tag_addr1, tag_data1, tag_wr1, wb_req, wb_index, wb_tag,
    input  tag_data0, wb_ack
  );

  modport slave (
    input  tag_addr0, tag_addr1, tag_data1, tag_wr1, wb_req, wb_index, wb_tag,
    output tag_data0, wb_ack
  );
endinterface

// File: rtl/dcache_tag_maint_ctrl.sv
// Owns both tag RAM ports: init sweep, invalidate-all and flush-all jobs, else zero-latency
// pass-through of core lookups/fills; core is stalled (ready low) for a whole job, writebacks wait on wb_ack.
module dcache_tag_maint_ctrl
  import dcache_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_req_i,
  input  logic       inv_req_i,
  output logic       busy_o,
  output logic       done_o,
  input  index_t     lookup_addr_i,
  output logic       lookup_ready_o,
  input  logic       fill_wr_i,
  input  index_t     fill_addr_i,
  input  tag_entry_t fill_data_i,
  output logic       fill_ready_o,
  dcache_tag_maint_ctrl_if.master tag_if
);

  state_t     state, state_nxt;
  index_t     idx, idx_nxt;
  addr_tag_t  wb_tag_q, wb_tag_nxt;
  tag_entry_t rd_entry;
  logic       maint;
  logic       seq_wr;

  assign rd_entry = tag_if.tag_data0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      idx      <= '0;
      wb_tag_q <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      wb_tag_q <= wb_tag_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    wb_tag_nxt = wb_tag_q;
    case (state)
      ST_INIT, ST_INV: begin
        idx_nxt = idx + 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = (state == ST_INIT) ? ST_IDLE : ST_DONE;
        end
      end
      ST_IDLE: begin
        if (flush_req_i) begin
          state_nxt = ST_F_RD;
          idx_nxt   = '0;
        end else if (inv_req_i) begin
          state_nxt = ST_INV;
          idx_nxt   = '0;
        end
      end
      ST_F_RD:  state_nxt = ST_F_CHK;
      ST_F_CHK: begin
        // Capture the tag now so the writeback payload stays stable while waiting for ack.
        if (rd_entry.tag_valid && rd_entry.tag_dirty) begin
          state_nxt  = ST_F_WB;
          wb_tag_nxt = rd_entry.tag_addr;
        end else begin
          state_nxt = ST_F_WR;
        end
      end
      ST_F_WB: begin
        if (tag_if.wb_ack) begin
          state_nxt = ST_F_WR;
        end
      end
      ST_F_WR: begin
        idx_nxt   = idx + 1'b1;
        state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_F_RD;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  assign maint  = (state != ST_IDLE);
  assign seq_wr = (state == ST_INIT) || (state == ST_INV) || (state == ST_F_WR);

  // Outputs are forced to their quiet values while rst is high so a reset mid-job
  // releases the RAM write port and the writeback request straight away.
  always_comb begin
    busy_o           = rst | (maint & (state != ST_DONE));
    done_o           = ~rst & (state == ST_DONE);
    lookup_ready_o   = ~rst & ~maint;
    fill_ready_o     = ~rst & ~maint;
    tag_if.tag_addr0 = '0;
    tag_if.tag_addr1 = '0;
    tag_if.tag_data1 = '0;
    tag_if.tag_wr1   = 1'b0;
    tag_if.wb_req    = 1'b0;
    tag_if.wb_index  = '0;
    tag_if.wb_tag    = '0;
    if (!rst) begin
      if (maint) begin
        tag_if.tag_addr0 = idx;
        tag_if.tag_addr1 = idx;
        tag_if.tag_wr1   = seq_wr;
      end else begin
        tag_if.tag_addr0 = lookup_addr_i;
        tag_if.tag_addr1 = fill_addr_i;
        tag_if.tag_data1 = fill_data_i;
        tag_if.tag_wr1   = fill_wr_i;
      end
      if (state == ST_F_WB) begin
        tag_if.wb_req   = 1'b1;
        tag_if.wb_index = idx;
        tag_if.wb_tag   = wb_tag_q;
      end
    end
  end

endmodule

// File: doc/dcache_tag_maint_ctrl.md
Name: dcache_tag_maint_ctrl

Overview:
- Sequencer and arbiter in front of the 256 x 21 dcache tag RAM.
- Owns both tag RAM ports and performs three jobs:
  - post-reset initialisation sweep;
  - software-requested invalidate-all;
  - flush-all, which writes back dirty lines and then invalidates them.
- Outside these jobs it forwards core lookups (read port) and fill updates (write port) unchanged.
- Sits between the dcache core pipeline, the tag RAM and the writeback/AXI path.

Parameters:
- NUM_LINES, 256, tag RAM depth; power of two.
- INDEX_W, 8, log2(NUM_LINES).
- TAG_W, 21, tag entry width.
- VALID_BIT, 20, entry valid flag position.
- DIRTY_BIT, 19, entry dirty flag position; bits 18:0 are the address tag.

Ports:
- clk  in  1  single clock, also drives tag RAM clk0/clk1
- rst  in  1  synchronous, active-high reset
- flush_req_i  in  1  flush-all request; level, held until done_o
- inv_req_i  in  1  invalidate-all request; level, held until done_o
- busy_o  out  1  maintenance in progress
- done_o  out  1  one-cycle pulse when a flush/invalidate job completes
- lookup_addr_i  in  INDEX_W  core lookup index
- lookup_ready_o  out  1  lookup index is being driven to the RAM this cycle
- fill_wr_i  in  1  core tag write request
- fill_addr_i  in  INDEX_W  core tag write index
- fill_data_i  in  TAG_W  core tag write data
- fill_ready_o  out  1  core tag write accepted this cycle
- tag_addr0_o  out  INDEX_W  RAM read address
- tag_data0_i  in  TAG_W  RAM read data; registered, valid 1 cycle after address; write-first
- tag_addr1_o  out  INDEX_W  RAM write address
- tag_data1_o  out  TAG_W  RAM write data
- tag_wr1_o  out  1  RAM write enable
- wb_req_o  out  1  writeback request for a dirty line
- wb_index_o  out  INDEX_W  line index to write back
- wb_tag_o  out  TAG_W-2  tag of the dirty line
- wb_ack_i  in  1  writeback complete

Behaviour:
- States:
  - INIT: reset entry state.
  - IDLE
  - INV: write sweep.
  - F_RD: present index.
  - F_CHK: examine read data.
  - F_WB: wait for ack.
  - F_WR: write invalid.
  - DONE
- Reset:
  - state = INIT, index counter = 0.
  - busy_o = 1; done_o, wb_req_o, tag_wr1_o, lookup_ready_o and fill_ready_o = 0.
  - Addresses/data = 0.
  - Reset mid-job aborts immediately: no pending writeback survives and wb_req_o drops the next cycle.
- INIT:
  - Writes 0 to entry `idx` each cycle, with `idx` incrementing.
  - After NUM_LINES cycles (idx wraps 255 -> 0) goes to IDLE.
  - No done_o pulse for INIT.
- IDLE:
  - busy_o = 0; lookup_ready_o = fill_ready_o = 1.
  - tag_addr0_o = lookup_addr_i.
  - tag_addr1_o/tag_data1_o/tag_wr1_o = the fill_* inputs.
  - Pure combinational pass-through, zero added latency; read data returns 1 cycle after address, as from the RAM.
- IDLE to job:
  - flush_req_i wins over inv_req_i when both are high.
  - Starting a job: busy_o = 1 next cycle, idx = 0; lookup_ready_o and fill_ready_o = 0 for the whole job.
  - A fill_wr_i in the same cycle the job starts is still accepted, because IDLE outputs are in effect.
- INV: identical to INIT (one write of 0 per cycle, NUM_LINES cycles), then DONE.
- Flush, per line:
  - F_RD: tag_addr0_o = idx.
  - F_CHK: if data[VALID_BIT] & data[DIRTY_BIT] -> F_WB, else -> F_WR.
  - F_WB: wb_req_o = 1 with index/tag held stable until wb_ack_i. An ack in the first F_WB cycle is legal. Then -> F_WR.
  - F_WR: write 0 to idx. If idx == NUM_LINES-1 -> DONE, else idx++ and -> F_RD.
  - Minimum cost is 3 cycles per clean line.
- DONE:
  - done_o = 1 for one cycle, then IDLE.
  - If the request is still high in IDLE the job restarts; requesters drop their request on done_o.
- Requests asserted while busy are not sampled.
- idx is INDEX_W bits and wraps naturally; there is no separate terminal counter.

Decomposition:
- Shared package dcache_pkg holds:
  - state encoding constants;
  - VALID_BIT and DIRTY_BIT;
  - the TAG_W field layout (tag_valid, tag_dirty, tag_addr slices).
- No sub-module: the index counter and the mux are inline. The mux is 2:1 on each RAM port, controlled by the state != IDLE signal.

Test Plan:
- Release rst with a RAM preloaded with 0x1FFFFF everywhere -> busy_o for exactly 256 cycles, every entry reads 0 after, no done_o pulse.
- IDLE lookups: lookup_addr_i=0x12, fill write 0x12 <- 0x100ABC in the same cycle -> next-cycle read returns 0x100ABC (write-first).
- inv_req_i with entries 3 and 200 valid -> busy 256 cycles, done_o single pulse, all entries 0, lookup_ready_o=0 throughout.
- Flush with entry 5 = 0x180033 (valid+dirty) and entry 9 = 0x100044 (valid only) -> exactly one wb_req_o with wb_index_o=5, wb_tag_o=0x33; hold wb_ack_i low 10 cycles -> request held stable; after completion all entries 0 and done_o pulses.
- flush_req_i and inv_req_i raised in the same cycle -> flush path taken (wb_req_o seen for dirty entry 255, last-index boundary).
- rst asserted while in F_WB -> wb_req_o low next cycle, INIT sweep restarts from index 0.
